axi_burst_reader: RTL and testbench
===================================

Name: axi_burst_reader

Overview:
- AXI4 read master that consumes the kick/read_addr/read_num/busy request interface produced by the HDMI line-prefetch address generator.
- Splits each request into INCR bursts of at most MAX_BURST beats, never crossing a 4 KB boundary.
- Streams returned beats into the pixel FIFO that feeds the HDMI timing stage.
- Drives busy back to the address generator so it can pace requests.

Parameters:
- DATA_WIDTH, 32, AXI data width and FIFO word width; legal values are 32, 64 and 128; one word per beat.
- MAX_BURST, 64, maximum beats per AR transaction; legal range 1..256.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; rst, synchronous, active-high; clock clk.
- kick  in  1  request strobe; held high by upstream until busy is seen high.
- read_addr  in  32  byte start address of the request.
- read_num  in  32  request length in words.
- busy  out  1  request in progress.
- rd_err  out  1  sticky error for the current request.
- m_axi_araddr  out  32  AR address.
- m_axi_arlen  out  8  AR length minus 1.
- m_axi_arsize  out  3  log2(DATA_WIDTH/8).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat of burst.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.
- fifo_din  out  DATA_WIDTH  FIFO write data.
- fifo_we  out  1  FIFO write enable.
- fifo_full  in  1  FIFO full.

Behaviour:
- Reset values: busy, m_axi_arvalid, m_axi_rready, fifo_we and rd_err are 0; m_axi_araddr and m_axi_arlen are 0.
- Reset mid-operation: return to IDLE immediately and drop all outputs to reset values. rst must be shared with the interconnect, so no orphan R beats arrive after reset.
- IDLE state:
  - busy=0.
  - kick=1 sampled at cycle N: latch the address with low log2(DATA_WIDTH/8) bits forced to 0, latch remaining=read_num, clear rd_err.
  - At N+1: busy=1, state=CALC.
- CALC state (1 cycle):
  - remaining==0: go to IDLE; busy is high for exactly one cycle and no AR is issued.
  - Otherwise compute beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) / (DATA_WIDTH/8)).
  - Load m_axi_araddr=addr and m_axi_arlen=beats-1, then go to AR.
- AR state: m_axi_arvalid=1 and AR outputs held stable until m_axi_arready=1. On that handshake: addr += beats*DATA_WIDTH/8, remaining -= beats, go to R.
- R state:
  - m_axi_rready = !fifo_full.
  - On each rvalid&&rready: fifo_din=rdata and fifo_we=1, both registered and appearing 1 cycle later. No beat may be dropped or duplicated.
  - rresp != 2'b00 sets rd_err.
  - rlast asserted on a beat other than the beats-th, or missing on the beats-th, sets rd_err. Count beats internally; end the burst on the beats-th beat regardless of rlast.
  - After the final beat: remaining>0 goes to CALC; remaining==0 goes to IDLE.
  - busy falls in the same cycle the state enters IDLE.
- Only one AR is outstanding at a time.
- kick while busy=1 is ignored.
- A new kick is accepted on the first IDLE cycle.
- Address arithmetic is 32-bit and wraps at 2^32 without error.
- fifo_full toggling every cycle: rready follows it combinationally from the registered fifo_full; no data loss.

Optional Feature:
- Macro: AXI_RD_SPACE_GATE_EN.
- When defined: add input fifo_space[31:0], the free FIFO words. In AR, m_axi_arvalid is asserted only while fifo_space >= beats + (number of in-flight fifo_we). Once asserted, arvalid stays high until arready.
- When undefined: the port is absent and AR is issued immediately on entering AR.

Test Plan:
- Aligned request, MAX_BURST=64, read_addr=0x0, read_num=256: 4 ARs at 0x000, 0x100, 0x200, 0x300, each arlen=63. Exactly 256 fifo_we in order. busy rises at N+1 and falls the cycle after the 256th beat.
- 4 KB crossing, read_addr=0xF80, read_num=64: AR 0xF80 with arlen=31, then AR 0x1000 with arlen=31. 64 beats written.
- Backpressure: fifo_full=1 for 10 cycles starting at beat 20 of 64. rready=0 and no fifo_we during that window. All 64 words reach the FIFO in order.
- read_num=0: busy high for exactly 1 cycle, arvalid never asserted, zero fifo_we.
- Error: rresp=2'b10 on beat 5 of 64 → rd_err=1 from the next cycle. Transfer still completes all 64 beats. rd_err cleared on the next accepted kick.
- Reset: rst asserted during beat 30 of a 256-word request → next cycle busy=0, arvalid=0, rready=0, fifo_we=0. A subsequent kick restarts cleanly from the new read_addr.

Source files
------------

// File: rtl/axi_burst_reader.sv
// AXI4 INCR read master: splits line requests into 4 KB-safe bursts into the pixel FIFO.
// Optional AXI_RD_SPACE_GATE_EN holds AR back until the FIFO has room for the burst.
module axi_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kick,
  input  logic [31:0]           read_addr,
  input  logic [31:0]           read_num,
  output logic                  busy,
  output logic                  rd_err,
  output logic [31:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  fifo_we,
`ifdef AXI_RD_SPACE_GATE_EN
  input  logic [31:0]           fifo_space,
`endif
  input  logic                  fifo_full
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam logic [31:0] ALIGN = ~32'(BYTES - 1);
  localparam logic [31:0] MAXB  = 32'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    AR,
    RD
  } state_t;

  state_t      state;
  logic [31:0] addr;
  logic [31:0] remaining;
  logic [31:0] beats;
  logic [31:0] cnt;
  logic [31:0] room;
  logic [31:0] cand;
  logic        rhs;
  logic        last;
  logic        space_ok;

`ifdef AXI_RD_SPACE_GATE_EN
  localparam bit GATE = 1'b1;
  // a pending fifo_we has not yet been reflected in fifo_space
  assign space_ok = fifo_space >= beats + {31'd0, fifo_we};
`else
  localparam bit GATE = 1'b0;
  assign space_ok = 1'b1;
`endif

  always_comb begin
    room = (32'd4096 - {20'd0, addr[11:0]}) >> SZ;
    cand = remaining;
    if (cand > MAXB) cand = MAXB;
    if (cand > room) cand = room;
  end

  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_rready  = (state == RD) && !fifo_full;
  assign rhs           = m_axi_rvalid && m_axi_rready;
  assign last          = (cnt == beats - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      rd_err        <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      fifo_din      <= '0;
      fifo_we       <= 1'b0;
      addr          <= '0;
      remaining     <= '0;
      beats         <= '0;
      cnt           <= '0;
    end else begin
      fifo_we <= rhs;
      if (rhs) fifo_din <= m_axi_rdata;
      unique case (state)
        IDLE: begin
          if (kick) begin
            addr      <= read_addr & ALIGN;
            remaining <= read_num;
            rd_err    <= 1'b0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          if (remaining == 32'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            beats         <= cand;
            m_axi_araddr  <= addr;
            m_axi_arlen   <= 8'(cand - 32'd1);
            m_axi_arvalid <= !GATE;
            cnt           <= '0;
            state         <= AR;
          end
        end
        AR: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            addr          <= addr + (beats << SZ);
            remaining     <= remaining - beats;
            state         <= RD;
          end else if (space_ok) begin
            m_axi_arvalid <= 1'b1;
          end
        end
        RD: begin
          if (rhs) begin
            cnt <= cnt + 32'd1;
            if (m_axi_rresp != 2'b00 || m_axi_rlast != last)
              rd_err <= 1'b1;
            // the local beat count, not rlast, closes the burst
            if (last) begin
              if (remaining == 32'd0) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= CALC;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Bench for axi_burst_reader: random AXI slave plus a queue-based request model.
module tb_axi_burst_reader;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          kick;
  logic [31:0]   read_addr;
  logic [31:0]   read_num;
  logic          busy;
  logic          rd_err;
  logic [31:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] fifo_din;
  logic          fifo_we;
  logic          fifo_full;
`ifdef AXI_RD_SPACE_GATE_EN
  logic [31:0]   fifo_space;
  assign fifo_space = 32'd4096;
`endif

  always #5 clk = ~clk;

  axi_burst_reader #(.DATA_WIDTH(DW), .MAX_BURST(64)) dut (
    .clk(clk), .rst(rst), .kick(kick),
    .read_addr(read_addr), .read_num(read_num),
    .busy(busy), .rd_err(rd_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .fifo_din(fifo_din), .fifo_we(fifo_we),
`ifdef AXI_RD_SPACE_GATE_EN
    .fifo_space(fifo_space),
`endif
    .fifo_full(fifo_full)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  // reference model: expected ARs and FIFO words for the active request
  logic [31:0] exp_ar_a[$];
  logic [7:0]  exp_ar_l[$];
  logic [31:0] exp_word[$];
  logic [31:0] ar_log_a[$];
  logic [7:0]  ar_log_l[$];
  int req_words = 0;
  int err_from = 0;
  int we_cnt = 0;
  int we_start = 0;
  int ar_start = 0;
  bit mon_en = 1'b0;

  task automatic model_req(input logic [31:0] a0, input logic [31:0] n);
    logic [31:0] a, rem, b, room;
    a = a0 & ~32'd3;
    rem = n;
    req_words = int'(n);
    while (rem != 0) begin
      room = (32'd4096 - {20'd0, a[11:0]}) / 4;
      b = rem;
      if (b > 32'd64) b = 32'd64;
      if (b > room) b = room;
      exp_ar_a.push_back(a);
      exp_ar_l.push_back(8'(b - 32'd1));
      for (int i = 0; i < int'(b); i++)
        exp_word.push_back(word_at(a + 32'(i) * 4));
      a = a + b * 4;
      rem = rem - b;
    end
  endtask

  // slave knobs
  int ff_mode = 0;
  logic ff_force = 1'b0;
  int ar_rate = 100;
  int r_rate = 100;
  int served = 0;
  int inj_err = 0;
  int inj_rl = 0;

  initial begin
    logic [31:0] sl_a[$];
    logic [7:0]  sl_l[$];
    int beat;
    logic arf, rf, rs;
    logic [31:0] aa;
    logic [7:0] ll;
    beat = 0;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0;
    fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      arf = m_axi_arvalid && m_axi_arready;
      rf = m_axi_rvalid && m_axi_rready;
      rs = rst;
      aa = m_axi_araddr;
      ll = m_axi_arlen;
      @(posedge clk);
      #1;
      if (rs === 1'b1) begin
        sl_a.delete();
        sl_l.delete();
        beat = 0;
        m_axi_rvalid = 1'b0;
      end else begin
        if (arf === 1'b1) begin
          sl_a.push_back(aa);
          sl_l.push_back(ll);
        end
        if (rf === 1'b1) begin
          served++;
          beat++;
          if (beat > int'(sl_l[0])) begin
            void'(sl_a.pop_front());
            void'(sl_l.pop_front());
            beat = 0;
          end
        end
      end
      m_axi_arready = ($urandom % 100) < ar_rate;
      case (ff_mode)
        1: fifo_full = 1'($urandom % 2);
        2: fifo_full = ~fifo_full;
        default: fifo_full = ff_force;
      endcase
      if (!(m_axi_rvalid && rf !== 1'b1)) begin
        if (sl_a.size() > 0 && ($urandom % 100) < r_rate) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata = word_at(sl_a[0] + 32'(beat) * 4);
          m_axi_rresp = (served + 1 == inj_err) ? 2'b10 : 2'b00;
          m_axi_rlast = (beat == int'(sl_l[0])) ^ (served + 1 == inj_rl);
        end else begin
          m_axi_rvalid = 1'b0;
        end
      end
    end
  end

  // single compare process against the model
  initial begin
    logic prev_full, prev_hold;
    logic [31:0] prev_a;
    logic [7:0] prev_l;
    int outstanding, idx;
    prev_full = 1'b0;
    prev_hold = 1'b0;
    prev_a = '0;
    prev_l = '0;
    outstanding = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_hold) begin
          chk("ar_hold_valid", 32'(m_axi_arvalid), 1);
          chk("ar_hold_addr", m_axi_araddr, prev_a);
          chk("ar_hold_len", 32'(m_axi_arlen), 32'(prev_l));
        end
        if (m_axi_rvalid && m_axi_rready) outstanding--;
        if (m_axi_arvalid && m_axi_arready) begin
          chk("one_ar", outstanding, 0);
          chk("arsize", 32'(m_axi_arsize), 2);
          chk("arburst", 32'(m_axi_arburst), 1);
          ar_log_a.push_back(m_axi_araddr);
          ar_log_l.push_back(m_axi_arlen);
          if (exp_ar_a.size() == 0) begin
            chk("ar_unexpected", 32'(exp_ar_a.size()), 1);
          end else begin
            chk("araddr", m_axi_araddr, exp_ar_a[0]);
            chk("arlen", 32'(m_axi_arlen), 32'(exp_ar_l[0]));
            void'(exp_ar_a.pop_front());
            void'(exp_ar_l.pop_front());
          end
          outstanding += int'(m_axi_arlen) + 1;
        end
        if (prev_full) chk("bp_we", 32'(fifo_we), 0);
        if (fifo_full) chk("bp_rready", 32'(m_axi_rready), 0);
        if (fifo_we) begin
          we_cnt++;
          if (exp_word.size() == 0) begin
            chk("we_unexpected", 32'(exp_word.size()), 1);
          end else begin
            chk("fifo_din", fifo_din, exp_word[0]);
            void'(exp_word.pop_front());
            idx = req_words - exp_word.size();
            chk("rd_err_at_word", 32'(rd_err),
                32'(err_from != 0 && idx >= err_from));
            chk("busy_at_word", 32'(busy), 32'(exp_word.size() != 0));
          end
        end
        prev_full = fifo_full && !rst;
        prev_hold = m_axi_arvalid && !m_axi_arready && !rst;
        prev_a = m_axi_araddr;
        prev_l = m_axi_arlen;
        if (rst) begin
          exp_word.delete();
          exp_ar_a.delete();
          exp_ar_l.delete();
          outstanding = 0;
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] n,
                        input int er, input int rl);
    inj_err = (er != 0) ? served + er : 0;
    inj_rl = (rl != 0) ? served + rl : 0;
    err_from = (er != 0 && (rl == 0 || er < rl)) ? er : rl;
    model_req(a, n);
    we_start = we_cnt;
    ar_start = ar_log_a.size();
    kick = 1'b1;
    read_addr = a;
    read_num = n;
    @(posedge clk);
    #1;
    chk("busy_rise", 32'(busy), 1);
    chk("err_clear", 32'(rd_err), 0);
    kick = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((busy || exp_word.size() != 0 || exp_ar_a.size() != 0)
           && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("done_in_budget", 32'(k < budget), 1);
    chk("final_err", 32'(rd_err), 32'(err_from != 0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (we_cnt - we_start < n && k < 5000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("words_in_budget", 32'(k < 5000), 1);
  endtask

  initial begin
    logic [31:0] a, n;
    int er, rl;
    rst = 1'b1;
    kick = 1'b0;
    read_addr = '0;
    read_num = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_arvalid", 32'(m_axi_arvalid), 0);
    chk("rst_rready", 32'(m_axi_rready), 0);
    chk("rst_we", 32'(fifo_we), 0);
    chk("rst_err", 32'(rd_err), 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", 32'(m_axi_arlen), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    do_req(32'h0, 32'd256, 0, 0);
    wait_done(5000);
    chk("t1_ar_count", ar_log_a.size() - ar_start, 4);
    chk("t1_ar1", ar_log_a[ar_start + 1], 32'h100);
    chk("t1_ar3", ar_log_a[ar_start + 3], 32'h300);
    chk("t1_len0", 32'(ar_log_l[ar_start]), 63);
    chk("t1_words", we_cnt - we_start, 256);

    do_req(32'hF80, 32'd64, 0, 0);
    wait_done(5000);
    chk("t2_ar_count", ar_log_a.size() - ar_start, 2);
    chk("t2_ar0", ar_log_a[ar_start], 32'hF80);
    chk("t2_len0", 32'(ar_log_l[ar_start]), 31);
    chk("t2_ar1", ar_log_a[ar_start + 1], 32'h1000);
    chk("t2_len1", 32'(ar_log_l[ar_start + 1]), 31);
    chk("t2_words", we_cnt - we_start, 64);

    do_req(32'h2000, 32'd64, 0, 0);
    wait_words(20);
    ff_force = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    ff_force = 1'b0;
    wait_done(5000);
    chk("t3_words", we_cnt - we_start, 64);

    do_req(32'h40, 32'd0, 0, 0);
    @(posedge clk);
    #1;
    chk("t4_busy_1cyc", 32'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_ar", ar_log_a.size() - ar_start, 0);
    chk("t4_no_we", we_cnt - we_start, 0);

    do_req(32'h3000, 32'd64, 5, 0);
    wait_done(5000);
    chk("t5_words", we_cnt - we_start, 64);

    ar_rate = 50;
    r_rate = 60;
    do_req(32'h4000, 32'd100, 0, 10);
    wait_done(5000);

    ff_mode = 2;
    do_req(32'h5010, 32'd150, 0, 0);
    wait_done(5000);
    chk("t6_words", we_cnt - we_start, 150);
    ff_mode = 0;
    ar_rate = 100;
    r_rate = 100;

    do_req(32'h0001_0000, 32'd256, 0, 0);
    wait_words(30);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t7_busy", 32'(busy), 0);
    chk("t7_arvalid", 32'(m_axi_arvalid), 0);
    chk("t7_rready", 32'(m_axi_rready), 0);
    chk("t7_we", 32'(fifo_we), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_req(32'h0001_2346, 32'd40, 0, 0);
    wait_done(5000);
    chk("t7_ar0", ar_log_a[ar_start], 32'h0001_2344);
    chk("t7_len0", 32'(ar_log_l[ar_start]), 39);
    chk("t7_words", we_cnt - we_start, 40);

    do_req(32'hFFFF_FFC0, 32'd64, 0, 0);
    wait_done(5000);
    chk("t8_ar0", ar_log_a[ar_start], 32'hFFFF_FFC0);
    chk("t8_len0", 32'(ar_log_l[ar_start]), 15);
    chk("t8_ar1", ar_log_a[ar_start + 1], 32'h0);
    chk("t8_len1", 32'(ar_log_l[ar_start + 1]), 47);

    for (int it = 0; it < 12; it++) begin
      a = $urandom;
      if ($urandom % 2 == 0) a = {a[31:12], 4'hF, a[7:0]};
      n = $urandom % 220;
      if ($urandom % 6 == 0) n = 0;
      er = 0;
      rl = 0;
      if (n != 0 && $urandom % 3 == 0) er = 1 + int'($urandom % n);
      if (n != 0 && $urandom % 3 == 0) rl = 1 + int'($urandom % n);
      ar_rate = 30 + int'($urandom % 71);
      r_rate = 30 + int'($urandom % 71);
      ff_mode = int'($urandom % 3);
      do_req(a, n, er, rl);
      wait_done(20000);
      chk("rnd_words", we_cnt - we_start, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
